// File: rtl/sample_pkg.sv
`default_nettype none
// ============================================================================
// Package : sample_pkg
// Desc    : Shared constants and width helpers for the sample decimator slice.
// Rev     : 1.0 - initial release
// ============================================================================
package sample_pkg;

  // Native sample width of the upstream smoothing filter
  localparam int SAMPLE_W = 8;

  // Accumulator width: one extra bit per doubling of the block length keeps
  // the running sum of a full block from wrapping.
  function automatic int acc_width(input int data_w, input int decim_log2);
    return data_w + decim_log2;
  endfunction

  // Ceiling log2, usable in constant expressions (pointer and level widths)
  function automatic int clog2_ceil(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage : sample_pkg
`default_nettype wire

// File: rtl/sample_decimator_if.sv
`default_nettype none
// ============================================================================
// Interface : sample_decimator_if
// Desc      : Sample input stream plus the buffered result handshake and
//             status of the decimator.
// Rev       : 1.0 - initial release
// ============================================================================
interface sample_decimator_if
  import sample_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int FIFO_DEPTH = 4
);

  localparam int LVL_W = clog2_ceil(FIFO_DEPTH) + 1;

  logic              in_valid;
  logic [DATA_W-1:0] data_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              overflow;

  // Producer of samples / consumer of results
  modport master (
    output in_valid, data_in, out_ready,
    input  out_valid, out_data, fifo_level, overflow
  );

  // The decimator itself
  modport slave (
    input  in_valid, data_in, out_ready,
    output out_valid, out_data, fifo_level, overflow
  );

endinterface : sample_decimator_if
`default_nettype wire

// File: rtl/sample_fifo.sv
`default_nettype none
// ============================================================================
// Module : sample_fifo
// Desc   : Small synchronous FIFO with counter-tracked level. A push into a
//          full FIFO is ignored unless a pop happens on the same edge.
// Rev    : 1.0 - initial release
// ============================================================================
module sample_fifo
  import sample_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 4
) (
  input  wire logic                       clk,
  input  wire logic                       rst_n,
  input  wire logic                       clr,
  input  wire logic                       push,
  input  wire logic                       pop,
  input  wire logic [WIDTH-1:0]           din,
  output logic      [WIDTH-1:0]           dout,
  output logic                            full,
  output logic                            empty,
  output logic      [clog2_ceil(DEPTH):0] level
);

  localparam int c_PTR_W = clog2_ceil(DEPTH);
  localparam int c_LVL_W = c_PTR_W + 1;
  localparam logic [c_LVL_W-1:0] c_FULL_LVL = c_LVL_W'(DEPTH);

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0] r_level;
  logic               w_do_pop;
  logic               w_do_push;

  assign empty     = (r_level == '0);
  assign full      = (r_level == c_FULL_LVL);
  assign w_do_pop  = pop & ~empty;
  // A simultaneous pop frees the slot the push needs
  assign w_do_push = push & (~full | w_do_pop);
  assign level     = r_level;
  // Head is forced to zero when nothing is stored
  assign dout      = empty ? '0 : r_mem[r_rd_ptr];

  // Pointer and level bookkeeping; pointers wrap naturally (DEPTH is 2**n)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_do_push && !w_do_pop)      r_level <= r_level + 1'b1;
      else if (w_do_pop && !w_do_push) r_level <= r_level - 1'b1;
    end
  end

  // Storage array; contents are only observable through dout when non-empty
  always_ff @(posedge clk) begin
    if (w_do_push && !clr) r_mem[r_wr_ptr] <= din;
  end

endmodule : sample_fifo
`default_nettype wire

// File: rtl/sample_decimator.sv
`default_nettype none
// ============================================================================
// Module : sample_decimator
// Desc   : Averages each block of 2**DECIM_LOG2 accepted samples into one
//          result and buffers the results for a slower consumer. A sticky
//          flag records any result dropped because the buffer was full.
// Rev    : 1.0 - initial release
// ============================================================================
module sample_decimator
  import sample_pkg::*;
#(
  parameter int DATA_W     = SAMPLE_W,
  parameter int DECIM_LOG2 = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr,
  sample_decimator_if.slave bus
);

  localparam int c_ACC_W = acc_width(DATA_W, DECIM_LOG2);
  localparam int c_CNT_W = (DECIM_LOG2 > 0) ? DECIM_LOG2 : 1;
  localparam int c_LVL_W = clog2_ceil(FIFO_DEPTH) + 1;
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'((1 << DECIM_LOG2) - 1);

  logic [c_ACC_W-1:0] r_acc;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_overflow;
  logic [c_ACC_W-1:0] w_sum;
  logic [DATA_W-1:0]  w_result;
  logic [DATA_W-1:0]  w_fifo_dout;
  logic [c_LVL_W-1:0] w_level;
  logic               w_accept;
  logic               w_last;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;

  // clr wins over both the incoming sample and the consumer's pop
  assign w_accept = bus.in_valid & ~clr;
  assign w_sum    = r_acc + c_ACC_W'(bus.data_in);
  assign w_last   = (r_cnt == c_CNT_LAST);
  // Divide by the block length by dropping the low bits (truncating)
  assign w_result = w_sum[DECIM_LOG2 +: DATA_W];
  assign w_push   = w_accept & w_last;
  assign w_pop    = bus.out_ready & ~w_empty & ~clr;

  // Block accumulator and sample counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (bus.in_valid) begin
      if (w_last) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Sticky overflow: set when a finished result finds no free slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow <= 1'b0;
    end else if (clr) begin
      r_overflow <= 1'b0;
    end else if (w_push && w_full && !w_pop) begin
      r_overflow <= 1'b1;
    end
  end

  sample_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (w_result),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .level (w_level)
  );

  assign bus.out_valid  = ~w_empty;
  assign bus.out_data   = w_fifo_dout;
  assign bus.fifo_level = w_level;
  assign bus.overflow   = r_overflow;

endmodule : sample_decimator
`default_nettype wire

// File: doc/sample_decimator.md
Name: sample_decimator

Overview:
Downstream stage of the 3-tap smoothing filter. It consumes the filter's 8-bit unsigned output stream and averages each block of 2**DECIM_LOG2 accepted samples into one output sample. Results are buffered in a small FIFO behind a valid/ready handshake, so a slower consumer such as a UART TX or display driver can drain them. Overrun is reported through a sticky flag.

Parameters:
DATA_W, 8, width of input and output samples (unsigned).
DECIM_LOG2, 2, log2 of the decimation factor N (default N=4); legal range 0..4.
FIFO_DEPTH, 4, number of result entries buffered; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
clr  in  1  synchronous clear of accumulator, counter, FIFO and overflow flag
in_valid  in  1  data_in is a valid sample this cycle (tie high when driven by the free-running filter)
data_in  in  DATA_W  filter output sample, unsigned
out_valid  out  1  FIFO non-empty; out_data holds the oldest result
out_ready  in  1  consumer accepts out_data this cycle
out_data  out  DATA_W  averaged sample at the FIFO head
fifo_level  out  clog2(FIFO_DEPTH)+1  number of results stored
overflow  out  1  sticky: at least one result was dropped

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect immediately, including mid-block):
  - acc=0, cnt=0, FIFO empty.
  - out_valid=0, out_data=0, fifo_level=0, overflow=0.
- Accumulation:
  - acc is DATA_W+DECIM_LOG2 bits wide, so it cannot overflow; cnt counts 0..N-1.
  - A sample is accepted on a rising edge with in_valid=1. Edges with in_valid=0 leave acc and cnt unchanged.
  - If cnt<N-1: acc+=data_in, cnt+=1.
  - If cnt==N-1: result=(acc+data_in)>>DECIM_LOG2, truncated and not rounded. On the same edge acc is set to 0, cnt to 0, and result is pushed.
- Latency: a result is pushed on the edge that accepts sample N of its block. When the FIFO was empty, out_valid=1 and out_data=result right after that edge.
- FIFO:
  - Write order is read order.
  - out_data = head entry; out_valid = !empty.
  - Pop on an edge with out_valid && out_ready.
  - out_data is held stable while out_valid && !out_ready.
  - out_data=0 when the FIFO is empty.
- Boundary cases:
  - Push and pop on the same edge when the FIFO is full: both happen, fifo_level is unchanged, no overflow.
  - Push and pop on the same edge when the FIFO is empty: not possible, because out_valid=0.
  - Push when full with no pop: the new result is dropped, the stored contents are unchanged, overflow is set to 1.
  - overflow is cleared only by rst_n or clr.
- clr=1 on an edge:
  - Sets acc=0, cnt=0, FIFO empty, overflow=0.
  - clr has priority over in_valid and out_ready on that edge: the sample is discarded and no pop is counted.
- DECIM_LOG2=0: every accepted sample is pushed directly into the FIFO (pass-through with buffering).
- Pointers: rd_ptr and wr_ptr each wrap modulo FIFO_DEPTH. fifo_level is tracked by a counter, not derived from the pointers.

Decomposition:
- Shared package sample_pkg holds:
  - constant SAMPLE_W=8;
  - the acc-width function (DATA_W+DECIM_LOG2);
  - the clog2 helper used for fifo_level and the pointers.
- One sub-module, sample_fifo: a synchronous FIFO with push, pop, full, empty, level and an asynchronous active-low reset, parameterised by width and depth.
- The top level holds the accumulator, cnt, the push logic and the overflow flag.

Test Plan:
1. Reset, then in_valid=1, out_ready=1, data 10,20,30,40 -> out_valid high for exactly one cycle, starting right after the 4th accepting edge, with out_data=25; overflow=0.
2. Four samples of 255 -> out_data=255 (no accumulator wrap). Samples 1,1,1,2 -> out_data=1 (truncation).
3. in_valid pattern 1,0,1,0,0,1,1 with data 8 on valid cycles -> exactly one result, out_data=8, pushed on the 4th valid edge; invalid cycles are ignored.
4. out_ready=0, 5 full blocks with block averages 1..5 -> fifo_level=4, overflow=1 after block 5. Then out_ready=1 -> outputs 1,2,3,4 in order, result 5 is lost, overflow stays 1.
5. FIFO full with out_ready=1 while block 5 completes -> 1 popped and 5 pushed on the same edge, fifo_level stays 4, overflow=0.
6. Assert rst_n=0 mid-block (cnt=2) between clock edges -> outputs go to 0 immediately, with no result from the partial block afterwards. Then clr=1 on the same edge as a valid sample with the FIFO holding 2 entries -> FIFO empty, sample discarded, overflow=0.
